cmp_skip_ctrl: RTL and testbench

//  Sequences the DR/AC equality datapath for compare-type instructions (SEQ, SNE, BEQ, CMP).
//  On start: fetches the operand from memory into DR, samples the external equality detector's EQ,

---
 rtl/cmp_skip_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_cmp_skip_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cmp_skip_ctrl.sv
// -----------------------------------------------------------------------------
// cmp_skip_ctrl
// Sequencer for the DR/AC equality datapath used by compare-type instructions
// (SEQ, SNE, BEQ, CMP). For each accepted start it reads one operand from
// memory into DR, waits one cycle for the external equality detector to settle
// on the new DR value, samples EQ and issues the next-PC update.
//
// Optional feature macro: CMP_TIMEOUT_EN
//   defined   : a REQ-state cycle counter aborts the memory read after TIMEOUT
//               cycles without mem_ack (err + done pulse, no PC write).
//   undefined : REQ waits indefinitely for mem_ack; err is constant 0.
// -----------------------------------------------------------------------------
module cmp_skip_ctrl #(
  parameter int WIDTH   = 19
`ifdef CMP_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 15
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] op_addr,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] target,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] dr_out,
  input  logic             eq_in,
  output logic [WIDTH-1:0] pc_out,
  output logic             pc_we,
  output logic             eq_flag,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_CMP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    M_SEQ = 2'b00,  // skip if EQ
    M_SNE = 2'b01,  // skip if !EQ
    M_BEQ = 2'b10,  // branch to target if EQ
    M_CMP = 2'b11   // update eq_flag only
  } mode_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t           state_q,    state_d;
  mode_t            mode_q,     mode_d;
  logic [WIDTH-1:0] pc_q,       pc_d;
  logic [WIDTH-1:0] target_q,   target_d;
  logic             mem_req_q,  mem_req_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] dr_q,       dr_d;
  logic [WIDTH-1:0] pc_out_q,   pc_out_d;
  logic             pc_we_q,    pc_we_d;
  logic             eq_flag_q,  eq_flag_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic             err_q,      err_d;

  // Asserted for the single REQ cycle in which the read is abandoned.
  logic             timeout_hit;

  // Candidate next-PC values, all wrapping modulo 2^WIDTH.
  logic [WIDTH-1:0] pc_plus1;
  logic [WIDTH-1:0] pc_plus2;

  assign pc_plus1 = pc_q + ONE;
  assign pc_plus2 = pc_q + TWO;

`ifdef CMP_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // REQ watchdog: counts REQ cycles; the read is abandoned at the end of the
  // TIMEOUT-th REQ cycle unless mem_ack arrives in that same cycle.
  // ---------------------------------------------------------------------------
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counter runs only while a read is outstanding and restarts on every entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == S_REQ) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign timeout_hit = (state_q == S_REQ) && !mem_ack &&
                       (cnt_q == CW'(TIMEOUT - 1));

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic for the IDLE -> REQ -> CMP -> IDLE flow.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every target gets a default before the case statement; a path that
    // skipped an assignment would otherwise infer a latch.
    state_d    = state_q;
    mode_d     = mode_q;
    pc_d       = pc_q;
    target_d   = target_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    dr_d       = dr_q;
    pc_out_d   = pc_out_q;
    eq_flag_d  = eq_flag_q;
    pc_we_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Operands are captured here so the caller may change them freely
        // while the operation is in flight.
        if (start) begin
          mode_d     = mode_t'(mode);
          pc_d       = pc_in;
          target_d   = target;
          mem_req_d  = 1'b1;
          mem_addr_d = op_addr;
          state_d    = S_REQ;
        end
      end

      S_REQ: begin
        // mem_req/mem_addr are held untouched until the read resolves.
        if (mem_ack) begin
          dr_d      = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = S_CMP;
        end else if (timeout_hit) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end

      S_CMP: begin
        // DR was loaded on entry, so eq_in now reflects the new operand.
        eq_flag_d = eq_in;
        done_d    = 1'b1;
        state_d   = S_IDLE;
        unique case (mode_q)
          M_SEQ: begin
            pc_out_d = eq_in ? pc_plus2 : pc_plus1;
            pc_we_d  = 1'b1;
          end
          M_SNE: begin
            pc_out_d = eq_in ? pc_plus1 : pc_plus2;
            pc_we_d  = 1'b1;
          end
          M_BEQ: begin
            pc_out_d = eq_in ? target_q : pc_plus1;
            pc_we_d  = 1'b1;
          end
          M_CMP: begin
            pc_out_d = pc_out_q;
            pc_we_d  = 1'b0;
          end
          default: begin
            pc_out_d = pc_out_q;
            pc_we_d  = 1'b0;
          end
        endcase
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // busy is registered, so it follows the state being entered.
    busy_d = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers; reset clears everything asynchronously.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments only, so every flop samples the values
    // from before this edge regardless of statement order.
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= M_SEQ;
      pc_q       <= '0;
      target_q   <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      dr_q       <= '0;
      pc_out_q   <= '0;
      pc_we_q    <= 1'b0;
      eq_flag_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      pc_q       <= pc_d;
      target_q   <= target_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      dr_q       <= dr_d;
      pc_out_q   <= pc_out_d;
      pc_we_q    <= pc_we_d;
      eq_flag_q  <= eq_flag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign dr_out   = dr_q;
  assign pc_out   = pc_out_q;
  assign pc_we    = pc_we_q;
  assign eq_flag  = eq_flag_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_cmp_skip_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cmp_skip_ctrl
// Directed bench for cmp_skip_ctrl. The equality detector is modelled as
// eq_in = (dr_out == ac); memory is a bench-driven ack with a chosen delay.
// Expected EQ and next-PC values are hand-computed per vector.
// -----------------------------------------------------------------------------
module tb_cmp_skip_ctrl;

  localparam int W = 19;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   mode;
  logic [W-1:0] op_addr;
  logic [W-1:0] pc_in;
  logic [W-1:0] target;
  logic         mem_req;
  logic [W-1:0] mem_addr;
  logic         mem_ack;
  logic [W-1:0] mem_rdata;
  logic [W-1:0] dr_out;
  logic         eq_in;
  logic [W-1:0] pc_out;
  logic         pc_we;
  logic         eq_flag;
  logic         busy;
  logic         done;
  logic         err;

  logic [W-1:0] ac;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // External equality detector: AC is a bench value, DR comes from the DUT.
  assign eq_in = (dr_out == ac);

  cmp_skip_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .op_addr   (op_addr),
    .pc_in     (pc_in),
    .target    (target),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .dr_out    (dr_out),
    .eq_in     (eq_in),
    .pc_out    (pc_out),
    .pc_we     (pc_we),
    .eq_flag   (eq_flag),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete operation. Cycle 0 is the cycle start is presented; ack is
  // given in REQ cycle ack_dly+1, so done is due in cycle ack_dly+3.
  task automatic run_op(input string tag, input logic [1:0] m,
                        input logic [W-1:0] addr, input logic [W-1:0] pc,
                        input logic [W-1:0] tgt, input logic [W-1:0] rd,
                        input logic [W-1:0] a, input int ack_dly,
                        input bit poke, input logic exp_eq,
                        input logic [W-1:0] exp_pc, input logic exp_we);
    bit req_ok  = 1'b1;
    bit err_hit = 1'b0;
    int lat;
    int extra_done = 0;
    @(negedge clk);
    mode = m; op_addr = addr; pc_in = pc; target = tgt; ac = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < ack_dly; i++) begin
      if (!(mem_req === 1'b1 && mem_addr === addr && busy === 1'b1)) req_ok = 1'b0;
      err_hit |= (err === 1'b1);
      if (poke && i == 0) begin
        start = 1'b1; op_addr = addr ^ 19'h00001; mode = ~m;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!(mem_req === 1'b1 && mem_addr === addr)) req_ok = 1'b0;
    mem_ack = 1'b1; mem_rdata = rd;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = ~rd;
    lat = ack_dly + 2;
    check({tag, "_req_drop"}, {31'd0, mem_req}, 32'd0);
    while (done !== 1'b1 && lat < ack_dly + 20) begin
      err_hit |= (err === 1'b1);
      @(negedge clk);
      lat++;
    end
    check({tag, "_req_stable"}, {31'd0, req_ok}, 32'd1);
    check({tag, "_latency"}, lat, ack_dly + 3);
    check({tag, "_pc_we"}, {31'd0, pc_we}, {31'd0, exp_we});
    check({tag, "_eq_flag"}, {31'd0, eq_flag}, {31'd0, exp_eq});
    check({tag, "_pc_out"}, {13'd0, pc_out}, {13'd0, exp_pc});
    check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_dr"}, {13'd0, dr_out}, {13'd0, rd});
    err_hit |= (err === 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra_done++;
      err_hit |= (err === 1'b1);
    end
    check({tag, "_single_done"}, extra_done, 0);
    check({tag, "_no_err"}, {31'd0, err_hit}, 32'd0);
    check({tag, "_pc_held"}, {13'd0, pc_out}, {13'd0, exp_pc});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'b00; op_addr = '0; pc_in = '0;
    target = '0; mem_ack = 1'b0; mem_rdata = '0; ac = 19'h00001;
    repeat (3) @(negedge clk);
    check("rst_outputs",
          {8'd0, mem_req, pc_we, eq_flag, busy, done, err, mem_addr, 18'd0} |
          {13'd0, dr_out} | {13'd0, pc_out}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    //     tag   mode   addr      pc        target    rdata     ac        dly poke eq    pc_out     we
    run_op("t1", 2'b00, 19'h00040, 19'h00100, 19'h00000, 19'd20,    19'd20,    0, 0, 1'b1, 19'h00102, 1'b1);
    run_op("t2", 2'b00, 19'h00041, 19'h00100, 19'h00000, 19'd20,    19'd40,    1, 0, 1'b0, 19'h00101, 1'b1);
    run_op("t3", 2'b01, 19'h00042, 19'h7FFFF, 19'h00000, 19'd29,    19'h7FFE3, 0, 0, 1'b0, 19'h00001, 1'b1);
    run_op("t4", 2'b10, 19'h01234, 19'h00200, 19'h00ABC, 19'h7FFEC, 19'h7FFEC, 5, 1, 1'b1, 19'h00ABC, 1'b1);
    run_op("t5", 2'b11, 19'h00050, 19'h00300, 19'h00000, 19'd5,     19'd5,     2, 0, 1'b1, 19'h00ABC, 1'b0);
    run_op("t6", 2'b01, 19'h00051, 19'h7FFFF, 19'h00000, 19'd7,     19'd7,     0, 0, 1'b1, 19'h00000, 1'b1);
    run_op("t7", 2'b10, 19'h00052, 19'h12345, 19'h7FFFF, 19'd2,     19'd1,     3, 0, 1'b0, 19'h12346, 1'b1);
    run_op("t8", 2'b00, 19'h00053, 19'h7FFFE, 19'h00000, 19'h7FFFE, 19'h7FFFE, 0, 1, 1'b1, 19'h00000, 1'b1);
    run_op("t9", 2'b11, 19'h00054, 19'h00010, 19'h00000, 19'd3,     19'd4,     0, 0, 1'b0, 19'h00000, 1'b0);

    // mem_ack while idle must not disturb DR or start anything.
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 19'h11111;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_dr", {13'd0, dr_out}, 32'h00003);
    check("stray_ack_busy", {30'd0, busy, done}, 32'd0);

`ifdef CMP_TIMEOUT_EN
    // No ack at all: REQ lasts 15 cycles, err+done land in cycle 16.
    begin
      int lat = 1;
      @(negedge clk);
      mode = 2'b00; op_addr = 19'h00060; pc_in = 19'h00020; ac = 19'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (done !== 1'b1 && lat < 60) begin
        @(negedge clk);
        lat++;
      end
      check("to_latency", lat, 16);
      check("to_err", {31'd0, err}, 32'd1);
      check("to_pc_we", {31'd0, pc_we}, 32'd0);
      check("to_mem_req", {31'd0, mem_req}, 32'd0);
      check("to_dr_kept", {13'd0, dr_out}, 32'h00003);
      @(negedge clk);
      check("to_after", {29'd0, busy, done, err}, 32'd0);
    end
`else
    // Without the watchdog a very late ack still completes normally.
    run_op("late", 2'b00, 19'h00060, 19'h00010, 19'h00000, 19'd3, 19'd3, 99, 0, 1'b1, 19'h00012, 1'b1);
`endif

    // Asynchronous reset in the middle of REQ.
    @(negedge clk);
    mode = 2'b00; op_addr = 19'h00070; pc_in = 19'h00400; ac = 19'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("pre_rst_req", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_req_drop", {31'd0, mem_req}, 32'd0);
    check("rst_busy_drop", {31'd0, busy}, 32'd0);
    check("rst_regs", {13'd0, dr_out} | {13'd0, pc_out} | {13'd0, mem_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", {29'd0, busy, done, mem_req}, 32'd0);
    run_op("t10", 2'b00, 19'h00071, 19'h00400, 19'h00000, 19'd9, 19'd9, 1, 0, 1'b1, 19'h00402, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
